// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator and pin output stage.
//
// A clock divider produces a one-clk pixel strobe (pix_en_o). On each strobe the horizontal
// counter advances, and the vertical counter advances when the horizontal counter wraps. The
// raw counters drive the pixel coordinate bus, so the downstream combinational drawing logic
// sees (x, y) with no added latency. Sync pulses and colour are registered onto the pins on the
// same strobe. Each pin therefore shows the pixel one strobe behind the counters, with sync and
// colour kept aligned.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   x_o, y_o       current horizontal / vertical count
//   blank_o        high outside the visible area
//   pix_en_o       one-clk strobe; the raster advances on this cycle
//   frame_start_o  one-clk pulse on the strobe that wraps the raster to (0,0)
//   rgb_in_i       colour for the current (x, y), from the drawing modules
//   vga_rgb_o      registered pin colour {R[3:0],G[3:0],B[3:0]}
//   vga_hs_o       registered horizontal sync, active-low
//   vga_vs_o       registered vertical sync, active-low
//
// Legal range: CLK_DIV 1..16. The horizontal and vertical totals must each be <= 2047.
module vga_timing #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] x_o,
  output logic [10:0] y_o,
  output logic        blank_o,
  output logic        pix_en_o,
  output logic        frame_start_o,
  input  logic [11:0] rgb_in_i,
  output logic [11:0] vga_rgb_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast      = 11'(HTotal - 1);
  localparam logic [10:0] VLast      = 11'(VTotal - 1);
  localparam logic [10:0] HVis       = 11'(H_VISIBLE);
  localparam logic [10:0] VVis       = 11'(V_VISIBLE);
  localparam logic [10:0] HSyncStart = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncStart = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VSyncEnd   = 11'(V_VISIBLE + V_FP + V_SYNC);

  // At least one bit is kept so that CLK_DIV = 1 still elaborates. In that case the divider
  // stays at 0 and the strobe is permanently high.
  localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [10:0]     hc_q, hc_d;
  logic [10:0]     vc_q, vc_d;
  logic            hs_q, vs_q;
  logic [11:0]     rgb_q;

  logic pix_en;
  logic blank;
  logic hs_comb;
  logic vs_comb;

  always_comb begin
    pix_en  = (div_q == DivLast);
    div_d   = pix_en ? '0 : div_q + DivW'(1);

    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (hc_q == HLast) begin
        hc_d = '0;
        vc_d = (vc_q == VLast) ? '0 : vc_q + 11'd1;
      end else begin
        hc_d = hc_q + 11'd1;
      end
    end

    blank   = (hc_q >= HVis) || (vc_q >= VVis);
    hs_comb = !((hc_q >= HSyncStart) && (hc_q < HSyncEnd));
    vs_comb = !((vc_q >= VSyncStart) && (vc_q < VSyncEnd));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      // The pin stage samples the pixel that the counters are leaving on this strobe.
      if (pix_en) begin
        hs_q  <= hs_comb;
        vs_q  <= vs_comb;
        rgb_q <= blank ? 12'h000 : rgb_in_i;
      end
    end
  end

  assign x_o           = hc_q;
  assign y_o           = vc_q;
  assign blank_o       = blank;
  assign pix_en_o      = pix_en;
  assign frame_start_o = pix_en && (hc_q == HLast) && (vc_q == VLast);
  assign vga_rgb_o     = rgb_q;
  assign vga_hs_o      = hs_q;
  assign vga_vs_o      = vs_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing. Two instances share a small raster geometry so that whole frames fit
// in a short run: instance A uses a divide-by-3 pixel clock and instance B uses divide-by-1.
// The expected raster state is derived from the number of clock edges since reset release.
// Expected pin values are queued on each pixel strobe and compared one strobe later.
module tb_vga_timing;

  localparam int unsigned HV  = 8;
  localparam int unsigned HFP = 2;
  localparam int unsigned HSW = 3;
  localparam int unsigned HBP = 2;
  localparam int unsigned VV  = 6;
  localparam int unsigned VFP = 1;
  localparam int unsigned VSW = 2;
  localparam int unsigned VBP = 2;
  localparam int unsigned HT  = HV + HFP + HSW + HBP;
  localparam int unsigned VT  = VV + VFP + VSW + VBP;
  localparam int unsigned DA  = 3;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        blank;
    logic        pix_en;
    logic        frame_start;
  } ras_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pin_t;

  localparam pin_t PinReset = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rgb_in;

  logic [10:0] a_x, a_y, b_x, b_y;
  logic        a_blank, a_pe, a_fs, a_hs, a_vs;
  logic        b_blank, b_pe, b_fs, b_hs, b_vs;
  logic [11:0] a_rgb, b_rgb;

  ras_t obs_a, obs_b;
  pin_t pins_a, pins_b;
  assign obs_a  = {a_x, a_y, a_blank, a_pe, a_fs};
  assign obs_b  = {b_x, b_y, b_blank, b_pe, b_fs};
  assign pins_a = {a_hs, a_vs, a_rgb};
  assign pins_b = {b_hs, b_vs, b_rgb};

  always #5 clk = ~clk;

  vga_timing #(
    .CLK_DIV(DA), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .x_o(a_x), .y_o(a_y), .blank_o(a_blank), .pix_en_o(a_pe),
    .frame_start_o(a_fs), .rgb_in_i(rgb_in), .vga_rgb_o(a_rgb), .vga_hs_o(a_hs),
    .vga_vs_o(a_vs)
  );

  vga_timing #(
    .CLK_DIV(1), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .x_o(b_x), .y_o(b_y), .blank_o(b_blank), .pix_en_o(b_pe),
    .frame_start_o(b_fs), .rgb_in_i(rgb_in), .vga_rgb_o(b_rgb), .vga_hs_o(b_hs),
    .vga_vs_o(b_vs)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned n;
  bit          fixed_rgb;
  pin_t        q_a[$];
  pin_t        q_b[$];
  pin_t        pin_a, pin_b;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at n=%0d t=%0t: got %0h expected %0h", tag, n, $time, obs, exp);
    end
  endtask

  function automatic ras_t model_ras(input int unsigned cnt, input int unsigned d);
    ras_t        r;
    int unsigned k, hc, vc;
    k             = cnt / d;
    hc            = k % HT;
    vc            = (k / HT) % VT;
    r.x           = 11'(hc);
    r.y           = 11'(vc);
    r.blank       = (hc >= HV) || (vc >= VV);
    r.pix_en      = (cnt % d) == (d - 1);
    r.frame_start = r.pix_en && (hc == HT - 1) && (vc == VT - 1);
    return r;
  endfunction

  function automatic pin_t model_pin(input ras_t r, input logic [11:0] c);
    pin_t        p;
    int unsigned hc, vc;
    hc    = int'(r.x);
    vc    = int'(r.y);
    p.hs  = !((hc >= HV + HFP) && (hc < HV + HFP + HSW));
    p.vs  = !((vc >= VV + VFP) && (vc < VV + VFP + VSW));
    p.rgb = r.blank ? 12'h000 : c;
    return p;
  endfunction

  task automatic check_dut(input string p, input ras_t o, input ras_t e, input pin_t po,
                           input pin_t pe);
    check_eq({p, "_x"}, 32'(o.x), 32'(e.x));
    check_eq({p, "_y"}, 32'(o.y), 32'(e.y));
    check_eq({p, "_blank"}, 32'(o.blank), 32'(e.blank));
    check_eq({p, "_pix_en"}, 32'(o.pix_en), 32'(e.pix_en));
    check_eq({p, "_frame_start"}, 32'(o.frame_start), 32'(e.frame_start));
    check_eq({p, "_hs"}, 32'(po.hs), 32'(pe.hs));
    check_eq({p, "_vs"}, 32'(po.vs), 32'(pe.vs));
    check_eq({p, "_rgb"}, 32'(po.rgb), 32'(pe.rgb));
  endtask

  // Called at a negedge: check state n, then drive colour and queue the pins it should produce.
  task automatic cycle_body(input bit live, output ras_t ra);
    ras_t rb;
    ra = model_ras(n, DA);
    rb = model_ras(n, 1);
    if (q_a.size() != 0) pin_a = q_a.pop_front();
    if (q_b.size() != 0) pin_b = q_b.pop_front();
    check_dut("a", obs_a, ra, pins_a, pin_a);
    check_dut("b", obs_b, rb, pins_b, pin_b);
    rgb_in = fixed_rgb ? 12'hf0f : 12'($urandom);
    if (live && ra.pix_en) q_a.push_back(model_pin(ra, rgb_in));
    if (live && rb.pix_en) q_b.push_back(model_pin(rb, rgb_in));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ras_t ra;
    bit   found;
    rst_n     = 1'b0;
    rgb_in    = 12'h000;
    n         = 0;
    fixed_rgb = 1'b0;
    pin_a     = PinReset;
    pin_b     = PinReset;

    repeat (3) begin
      @(negedge clk);
      cycle_body(1'b0, ra);
    end

    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    repeat (1100) begin
      cycle_body(1'b1, ra);
      @(negedge clk);
      n++;
    end

    // Run to a point inside A's horizontal sync so that vga_hs is low when reset hits.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      cycle_body(1'b1, ra);
      if (ra.x == 11'd11 && ra.y == 11'd3 && !ra.pix_en) begin
        found = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("hsync_window_reached", 32'(found), 32'd1);

    #2 rst_n = 1'b0;
    #1;
    q_a.delete();
    q_b.delete();
    pin_a = PinReset;
    pin_b = PinReset;
    n     = 0;
    check_dut("async_rst_a", obs_a, model_ras(0, DA), pins_a, PinReset);
    check_dut("async_rst_b", obs_b, model_ras(0, 1), pins_b, PinReset);

    repeat (2) begin
      @(negedge clk);
      cycle_body(1'b0, ra);
    end

    @(negedge clk);
    rst_n     = 1'b1;
    n         = 0;
    fixed_rgb = 1'b1;
    repeat (600) begin
      cycle_body(1'b1, ra);
      @(negedge clk);
      n++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
